// File: rtl/arb_client_port.sv
// arb_client_port: requester-side front end for a round-robin arbiter.
// A small FIFO buffers producer words. req is raised whenever the FIFO
// holds data. On gnt, the head word is presented on the shared bus in
// the same cycle.
// Optional feature: define ARB_CLIENT_STARVE_EN to build the wait
// counter and the starve flag. When it is undefined, starve is tied to 0.
module arb_client_port #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          req,
    input  logic                          gnt,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          starve
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_GRANTED = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_req;

    // req depends only on registered occupancy, so no path runs from gnt back through the arbiter.
    assign w_req  = (r_count != {CNT_W{1'b0}});
    assign w_push = in_valid && (r_count != FULL_CNT);
    assign w_pop  = w_req && gnt;

    // Next occupancy: a full FIFO refuses pushes even when a pop happens in the same cycle.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage write port; the data array carries no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; power-of-two depth makes pointer wrap natural.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: IDLE -> PEND on push, PEND -> GRANTED on grant, GRANTED settles by occupancy.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) w_state_nxt = ST_PEND;
                else        w_state_nxt = ST_IDLE;
            end
            ST_PEND: begin
                if (w_pop) w_state_nxt = ST_GRANTED;
                else       w_state_nxt = ST_PEND;
            end
            ST_GRANTED: begin
                if (w_count_nxt == {CNT_W{1'b0}}) w_state_nxt = ST_IDLE;
                else if (w_pop)                   w_state_nxt = ST_GRANTED;
                else                              w_state_nxt = ST_PEND;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: bus transfer happens in the grant cycle; data reads as zero when empty.
    always_comb begin
        req       = w_req;
        in_ready  = (r_count != FULL_CNT);
        out_valid = w_pop;
        count     = r_count;
        if (w_req) out_data = r_mem[r_rd_ptr];
        else       out_data = {DATA_WIDTH{1'b0}};
    end

`ifdef ARB_CLIENT_STARVE_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] r_wait_cnt;

    // Wait counter: cleared by a transfer and outside PEND, saturates at TIMEOUT while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (w_pop) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else begin
            case (r_state)
                ST_PEND: begin
                    if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    else                        r_wait_cnt <= r_wait_cnt;
                end
                default: r_wait_cnt <= {WAIT_W{1'b0}};
            endcase
        end
    end

    assign starve = (r_wait_cnt == WAIT_MAX);
`else
    assign starve = 1'b0;
`endif

endmodule
